// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the memory read responder.
//   state_e     - responder FSM states (IDLE, WAIT, DONE)
//   DEF_*       - default values for DATA_W, DEPTH and LATENCY
//   addr_ok()   - true when a byte address is word aligned and inside the array
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_LATENCY = 2;

  // Compare in 64 bits so 4*depth can never wrap against a 32-bit address.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && ({32'd0, addr} < (64'(depth) * 64'd4));
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: word storage with one synchronous read port.
//   clk      - clock (rising edge)
//   rst_n    - synchronous active-low reset; clears only the read register
//   rd_en    - load rd_data with mem[rd_idx] at this edge
//   rd_clr   - force rd_data to zero at this edge (wins over rd_en)
//   rd_idx   - word index to read
//   rd_data  - registered read data, holds between loads
//   wr_en/wr_idx/wr_data - optional write port, present with MEM_WRITE_PORT_EN
// Contents are never touched by reset. Without MEM_WRITE_PORT_EN the array is
// read-only and starts at zero.
module mem_array
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [AW-1:0]     rd_idx,
`ifdef MEM_WRITE_PORT_EN
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_idx,
  input  logic [DATA_W-1:0] wr_data,
`endif
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_clr)     rd_data_d = '0;
    else if (rd_en) rd_data_d = mem_q[rd_idx];
  end

  // Read samples mem_q before the write below lands, so a same-edge write to
  // the word being read returns the old contents.
  always_ff @(posedge clk) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

`ifdef MEM_WRITE_PORT_EN
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end
`endif

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_read_responder.sv
// mem_read_responder: single-outstanding read responder with a fixed wait.
//   CLOCK_50    - clock (rising edge)
//   resetIn     - synchronous active-low reset
//   enable      - request strobe in IDLE, acknowledge release in DONE
//   readAddress - byte address captured on the request edge
//   dataRead    - registered read data (zero on address error)
//   acknowledge - high while in DONE
//   addrError   - misaligned or out-of-range request, valid with acknowledge
//   writeEnable/writeAddress/writeData - optional write port (MEM_WRITE_PORT_EN)
module mem_read_responder
  import mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              CLOCK_50,
  input  logic              resetIn,
  input  logic              enable,
  input  logic [31:0]       readAddress,
`ifdef MEM_WRITE_PORT_EN
  input  logic              writeEnable,
  input  logic [31:0]       writeAddress,
  input  logic [DATA_W-1:0] writeData,
`endif
  output logic [DATA_W-1:0] dataRead,
  output logic              acknowledge,
  output logic              addrError
);

  localparam int AW = $clog2(DEPTH);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        rd_en, rd_clr;
  logic        addr_valid;

  assign addr_valid = addr_ok(addr_q, DEPTH);

  // WAIT spends LATENCY+1 cycles: the counter is loaded with LATENCY, counts
  // down to zero, and the zero cycle is the one that issues the read.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ack_d   = ack_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    rd_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          addr_d  = readAddress;
          cnt_d   = 4'(LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          ack_d   = 1'b1;
          err_d   = !addr_valid;
          rd_en   = addr_valid;
          rd_clr  = !addr_valid;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        // Releasing enable only returns to IDLE; a new request needs another
        // enable seen in IDLE.
        if (enable) begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetIn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

`ifdef MEM_WRITE_PORT_EN
  logic wr_en;
  assign wr_en = writeEnable && addr_ok(writeAddress, DEPTH);
`endif

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk     (CLOCK_50),
    .rst_n   (resetIn),
    .rd_en   (rd_en),
    .rd_clr  (rd_clr),
    .rd_idx  (addr_q[AW+1:2]),
`ifdef MEM_WRITE_PORT_EN
    .wr_en   (wr_en),
    .wr_idx  (writeAddress[AW+1:2]),
    .wr_data (writeData),
`endif
    .rd_data (dataRead)
  );

  assign acknowledge = ack_q;
  assign addrError   = err_q;

endmodule

// File: tb/tb_mem_read_responder.sv
module tb_mem_read_responder;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, en1 = 1'b0, en15 = 1'b0;
  logic [31:0] ra = '0;
  logic [31:0] dataRead, data1, data15;
  logic        ack, ack1, ack15;
  logic        err, err1, err15;
`ifdef MEM_WRITE_PORT_EN
  logic        we = 1'b0;
  logic [31:0] wa = '0;
  logic [31:0] wd = '0;
`endif

  always #10 clk = ~clk;

  mem_read_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(2)) dut (
    .CLOCK_50(clk), .resetIn(rst_n), .enable(en), .readAddress(ra),
`ifdef MEM_WRITE_PORT_EN
    .writeEnable(we), .writeAddress(wa), .writeData(wd),
`endif
    .dataRead(dataRead), .acknowledge(ack), .addrError(err));

  mem_read_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(1)) dut_l1 (
    .CLOCK_50(clk), .resetIn(rst_n), .enable(en1), .readAddress(ra),
`ifdef MEM_WRITE_PORT_EN
    .writeEnable(we), .writeAddress(wa), .writeData(wd),
`endif
    .dataRead(data1), .acknowledge(ack1), .addrError(err1));

  mem_read_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(15)) dut_l15 (
    .CLOCK_50(clk), .resetIn(rst_n), .enable(en15), .readAddress(ra),
`ifdef MEM_WRITE_PORT_EN
    .writeEnable(we), .writeAddress(wa), .writeData(wd),
`endif
    .dataRead(data15), .acknowledge(ack15), .addrError(err15));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Issue a request on the main DUT; expected result goes to the scoreboard
  // and is popped when acknowledge rises. readAddress is scrambled after the
  // capture edge to show the in-flight transaction ignores it.
  task automatic request(input string tag, input logic [31:0] addr,
                         input logic [31:0] d, input logic e);
    int   n;
    exp_t x;
    sb.push_back({d, e});
    ra = addr;
    en = 1'b1;
    tick();
    en = 1'b0;
    ra = ~addr;
    n  = 0;
    while (ack !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd3);
    check({tag, "_ack"}, 64'(ack), 64'd1);
    x = sb.pop_front();
    check({tag, "_data"}, 64'(dataRead), 64'(x.data));
    check({tag, "_err"}, 64'(err), 64'(x.err));
  endtask

  task automatic release_done(input string tag);
    en = 1'b1;
    tick();
    en = 1'b0;
    check({tag, "_rel"}, 64'(ack), 64'd0);
  endtask

`ifdef MEM_WRITE_PORT_EN
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1;
    wa = a;
    wd = d;
    tick();
    we = 1'b0;
  endtask
`endif

  initial begin
    int n1, n15;
    exp_t x;

    // Reset state
    tick();
    tick();
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_data", 64'(dataRead), 64'd0);

    // Preload
`ifdef MEM_WRITE_PORT_EN
    wr(32'h10, 32'hDEADBEEF);
    wr(32'h3FC, 32'hA5A50001);
    wr(32'h20, 32'hCAFE0008);
`else
    dut.u_array.mem_q[4]   = 32'hDEADBEEF;
    dut.u_array.mem_q[255] = 32'hA5A50001;
`endif
    rst_n = 1'b1;

    // Basic read, then hold in DONE
    request("rd10", 32'h10, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_ack", 64'(ack), 64'd1);
      check("hold_data", 64'(dataRead), 64'hDEADBEEF);
    end
    release_done("rd10");
    for (int i = 0; i < 5; i++) tick();
    check("norestart_ack", 64'(ack), 64'd0);
    check("retain_data", 64'(dataRead), 64'hDEADBEEF);

    // Address errors and last valid word
    request("mis13", 32'h13, 32'h0, 1'b1);
    release_done("mis13");
    request("oor400", 32'h400, 32'h0, 1'b1);
    release_done("oor400");
    request("last3fc", 32'h3FC, 32'hA5A50001, 1'b0);
    release_done("last3fc");

    // Reset one cycle after capture aborts the transaction
    ra = 32'h10;
    en = 1'b1;
    tick();
    en = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_ack", 64'(ack), 64'd0);
    check("abort_err", 64'(err), 64'd0);
    check("abort_data", 64'(dataRead), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    check("abort_noack", 64'(ack), 64'd0);
    request("post_rst", 32'h10, 32'hDEADBEEF, 1'b0);
    release_done("post_rst");

`ifdef MEM_WRITE_PORT_EN
    // Same-edge write to the word being read returns the old data
    sb.push_back({32'hCAFE0008, 1'b0});
    ra = 32'h20;
    en = 1'b1;
    tick();          // capture
    en = 1'b0;
    tick();
    tick();
    we = 1'b1;
    wa = 32'h20;
    wd = 32'h12345678;
    tick();          // WAIT->DONE edge, write lands here too
    we = 1'b0;
    x = sb.pop_front();
    check("rbw_ack", 64'(ack), 64'd1);
    check("rbw_data", 64'(dataRead), 64'(x.data));
    release_done("rbw");
    wr(32'h21, 32'h0BAD0BAD);
    wr(32'h400, 32'h0BAD0BAD);
    request("after_wr", 32'h20, 32'h12345678, 1'b0);
    release_done("after_wr");
`endif

    // LATENCY=1 and LATENCY=15 instances
    ra   = 32'h8;
    en1  = 1'b1;
    en15 = 1'b1;
    tick();
    en1  = 1'b0;
    en15 = 1'b0;
    n1   = 0;
    n15  = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ack1 === 1'b1 && n1 == 0) n1 = i;
      if (ack15 === 1'b1 && n15 == 0) n15 = i;
    end
    check("lat1", 64'(n1), 64'd2);
    check("lat15", 64'(n15), 64'd16);
    check("lat1_data", 64'(data1), 64'd0);
    check("lat15_err", 64'(err15), 64'd0);
    en1  = 1'b1;
    en15 = 1'b1;
    tick();
    en1  = 1'b0;
    en15 = 1'b0;
    check("lat1_rel", 64'(ack1), 64'd0);
    check("lat15_rel", 64'(ack15), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
